// File: rtl/shared_reg_arbiter_pkg.sv
// shared_reg_arbiter_pkg: state encodings and hold-counter width shared by the arbiter
package shared_reg_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr with wrap
module rr_pick #(
  parameter int NREQ = 4,
  localparam int W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [W-1:0]    ptr,
  output logic [W-1:0]    winner,
  output logic            valid
);
  logic [W-1:0] idx;
  // scan offsets downward so the smallest offset from ptr is the last to win
  always_comb begin
    winner = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = W'((int'(ptr) + k) % NREQ);
      if (req[idx]) winner = idx;
    end
    valid = |req;
  end
endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin sharing of one WIDTH-bit register among NREQ requesters
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter int HOLD_CYCLES = 2,
  localparam int W = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*WIDTH-1:0] Data,
  output logic [NREQ-1:0]       Grant,
  output logic [WIDTH-1:0]      Q,
  output logic [W-1:0]          Owner,
  output logic                  Busy,
  output logic                  Done
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0] ptr, win_q, winner;
  logic valid;
  logic [WIDTH-1:0] slices [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slices[i] = Data[i*WIDTH +: WIDTH];
  end
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req(Req),
    .ptr(ptr),
    .winner(winner),
    .valid(valid)
  );
  // arbitration FSM: grant in IDLE, single-cycle load, counted hold, pointer advances on completion
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state <= IDLE;
      Grant <= '0;
      Q <= '0;
      Owner <= '0;
      Busy <= 1'b0;
      Done <= 1'b0;
      ptr <= '0;
      win_q <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (valid) begin
            Grant <= NREQ'(1) << winner;
            Busy <= 1'b1;
            win_q <= winner;
            state <= LOAD;
          end
        end
        LOAD: begin
          Q <= slices[win_q];
          Owner <= win_q;
          cnt <= CNT_W'(HOLD_CYCLES - 1);
          state <= HOLD;
        end
        HOLD: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            Grant <= '0;
            Busy <= 1'b0;
            Done <= 1'b1;
            ptr <= (win_q == W'(NREQ - 1)) ? '0 : win_q + 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          Grant <= '0;
          Busy <= 1'b0;
          Done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed and random checks of the arbiter against a transaction-level model
module tb_shared_reg_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 2;
  logic CLK = 1'b0;
  logic Reset;
  logic [N-1:0] Req;
  logic [N*W-1:0] Data;
  logic [N-1:0] Grant;
  logic [W-1:0] Q;
  logic [1:0] Owner;
  logic Busy, Done;
  int checks = 0;
  int errors = 0;
  bit armed = 0;
  shared_reg_arbiter #(.NREQ(N), .WIDTH(W), .HOLD_CYCLES(H)) dut (
    .CLK(CLK),
    .Reset(Reset),
    .Req(Req),
    .Data(Data),
    .Grant(Grant),
    .Q(Q),
    .Owner(Owner),
    .Busy(Busy),
    .Done(Done)
  );
  always #5 CLK = ~CLK;
  int m_age = -1;
  int m_win = 0;
  int m_ptr = 0;
  int m_q = 0;
  int m_grant = 0;
  int m_owner = 0;
  int m_busy = 0;
  int m_done = 0;
  // reference: a transfer is an age counted in edges since its grant
  always @(posedge CLK) begin
    if (!Reset) begin
      m_age = -1; m_ptr = 0; m_q = 0; m_grant = 0; m_owner = 0; m_busy = 0; m_done = 0;
    end else if (m_age < 0) begin
      m_done = 0;
      if (Req != 0) begin
        for (int k = N - 1; k >= 0; k--)
          if (Req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
        m_age = 0;
        m_grant = 1 << m_win;
        m_busy = 1;
      end
    end else begin
      m_age++;
      if (m_age == 1) begin
        m_q = int'(Data[m_win*W +: W]);
        m_owner = m_win;
      end
      if (m_age == H + 1) begin
        m_grant = 0; m_busy = 0; m_done = 1;
        m_ptr = (m_win + 1) % N;
        m_age = -1;
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask
  // compare every output with the model away from the active edge
  always @(negedge CLK) begin
    if (armed) begin
      chk("model_grant", int'(Grant), m_grant);
      chk("model_q", int'(Q), m_q);
      chk("model_owner", int'(Owner), m_owner);
      chk("model_busy", int'(Busy), m_busy);
      chk("model_done", int'(Done), m_done);
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask
  initial begin
    Reset = 1'b0;
    Req = 4'hF;
    Data = '0;
    step(1);
    armed = 1;
    for (int r = 0; r < 2; r++) begin
      chk("rst_q", int'(Q), 0);
      chk("rst_grant", int'(Grant), 0);
      chk("rst_owner", int'(Owner), 0);
      chk("rst_busy_done", int'({Busy, Done}), 0);
      if (r == 0) step(1);
    end
    Reset = 1'b1;
    Req = 4'b0100;
    Data = 32'h00A5_0000;
    step(1);
    chk("single_grant", int'(Grant), 4'b0100);
    Req = 4'b0000;
    step(1);
    chk("single_q", int'(Q), 8'hA5);
    chk("single_owner", int'(Owner), 2);
    step(1);
    chk("single_no_early_done", int'(Done), 0);
    step(1);
    chk("single_done", int'(Done), 1);
    chk("single_done_grant", int'(Grant), 0);
    step(1);
    chk("single_done_pulse", int'(Done), 0);
    Reset = 1'b0;
    step(1);
    Reset = 1'b1;
    Req = 4'b1111;
    Data = 32'h4433_2211;
    step(1);
    for (int k = 0; k < 4; k++) begin
      chk("fair_grant", int'(Grant), 1 << k);
      step(1);
      chk("fair_q", int'(Q), 8'h11 * (k + 1));
      if (k == 3) Req = 4'b1001;
      step(3);
    end
    chk("wrap_grant", int'(Grant), 4'b0001);
    step(4);
    chk("skip_grant", int'(Grant), 4'b1000);
    Req = 4'b0000;
    step(1);
    chk("stab_q_load", int'(Q), 8'h44);
    Data = '1;
    step(1);
    chk("stab_q_hold", int'(Q), 8'h44);
    step(1);
    chk("stab_done", int'(Done), 1);
    chk("stab_q_done", int'(Q), 8'h44);
    step(2);
    chk("stab_no_grant", int'(Grant), 0);
    Data = 32'h4433_2211;
    Req = 4'b0100;
    step(1);
    chk("mid_grant", int'(Grant), 4'b0100);
    Req = 4'b0000;
    step(1);
    chk("mid_q", int'(Q), 8'h33);
    Reset = 1'b0;
    step(1);
    chk("mid_rst_grant", int'(Grant), 0);
    chk("mid_rst_q", int'(Q), 0);
    chk("mid_rst_done", int'(Done), 0);
    Reset = 1'b1;
    step(2);
    chk("mid_no_done", int'(Done), 0);
    Req = 4'b1111;
    step(1);
    chk("mid_after_grant", int'(Grant), 4'b0001);
    for (int c = 0; c < 3000; c++) begin
      Reset = ($urandom_range(0, 63) != 0);
      Req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) Req = '0;
      Data = $urandom;
      step(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
